sbox_inverter: RTL and testbench

Consumes the completed substitution box after the S-box builder raises done_sbox. It reads all 256 entries over a synchronous read port and builds the inverse S-box in an internal 256x8 table (inv[sbox[a]] = a). It checks that the table is a permutation. It then serves the decryption-side inverse-substitution lookups over a valid/ready stream.

---
 rtl/sbox_inverter.sv | 177 +++++++++++++++++
 tb/tb_sbox_inverter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_inverter.sv
// sbox_inverter: reads a completed 256-entry S-box, builds its inverse table,
// flags duplicate values, then serves inverse lookups over a valid/ready stream.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begin a fill (sampled only while idle)
//   sbox_rd_en/addr   - read request to S-box storage
//   sbox_rd_data      - read data, one cycle after the request
//   done_inv          - inverse table valid, lookups enabled
//   err_dup           - sticky: some value appeared twice in the S-box
//   in_valid/data/ready   - lookup request stream
//   out_valid/data/ready  - lookup result stream (1-cycle latency)
module sbox_inverter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             sbox_rd_en,
  output logic [WIDTH-1:0] sbox_rd_addr,
  input  logic [WIDTH-1:0] sbox_rd_data,
  output logic             done_inv,
  output logic             err_dup,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned DEPTH = 32'd1 << WIDTH;
  localparam int unsigned CNT_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

  // Only a single-cycle read pipeline is modelled by the write-qualify stage.
  if (RD_LAT != 1) begin : g_bad_rd_lat
    $error("sbox_inverter: only RD_LAT == 1 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_en_q, rd_en_d;
  logic             rd_vld_q, rd_vld_d;
  logic [WIDTH-1:0] addr_d1_q, addr_d1_d;
  logic [DEPTH-1:0] bitmap_q, bitmap_d;
  logic             err_dup_q, err_dup_d;
  logic             done_q, done_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] inv_q [DEPTH];

  logic             wr_en_c;
  logic             dup_c;
  logic             accept_c;

  // Next-state, write-path and lookup logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_en_d     = 1'b0;
    rd_vld_d    = rd_en_q;
    addr_d1_d   = cnt_q[WIDTH-1:0];
    bitmap_d    = bitmap_q;
    err_dup_d   = err_dup_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    accept_c    = 1'b0;

    // Read data returned this cycle belongs to the address issued last cycle.
    wr_en_c = rd_vld_q && ((state_q == S_FILL) || (state_q == S_FLUSH));
    dup_c   = wr_en_c && bitmap_q[sbox_rd_data];
    if (wr_en_c) begin
      bitmap_d[sbox_rd_data] = 1'b1;
    end
    if (dup_c) begin
      err_dup_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          rd_en_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        // Counter runs past 255 so the address output returns to 0 afterwards;
        // termination is the explicit compare, never the wrap.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = S_FLUSH;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (err_dup_q || dup_c) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        in_ready = !out_valid_q || out_ready;
        accept_c = in_valid && in_ready;
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_data_d  = inv_q[in_data];
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      S_ERROR: begin
        done_d      = 1'b0;
        out_valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      addr_d1_q   <= '0;
      bitmap_q    <= '0;
      err_dup_q   <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      rd_vld_q    <= rd_vld_d;
      addr_d1_q   <= addr_d1_d;
      bitmap_q    <= bitmap_d;
      err_dup_q   <= err_dup_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Inverse table storage; contents are don't-care until a fill completes.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      inv_q[sbox_rd_data] <= addr_d1_q;
    end
  end

  assign sbox_rd_en   = rd_en_q;
  assign sbox_rd_addr = cnt_q[WIDTH-1:0];
  assign done_inv     = done_q;
  assign err_dup      = err_dup_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;

endmodule

// File: tb/tb_sbox_inverter.sv
// Self-checking bench for sbox_inverter: S-box storage model, inverse-table
// reference model, directed lookup table and randomized stream scoreboard.
module tb_sbox_inverter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sbox_rd_en;
  logic [7:0] sbox_rd_addr;
  logic [7:0] sbox_rd_data;
  logic       done_inv;
  logic       err_dup;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  always #5 clk = ~clk;

  sbox_inverter #(.WIDTH(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sbox_rd_en(sbox_rd_en), .sbox_rd_addr(sbox_rd_addr), .sbox_rd_data(sbox_rd_data),
    .done_inv(done_inv), .err_dup(err_dup),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  logic [7:0] sbox_mem  [256];
  logic [7:0] model_inv [256];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [7:0] din;
    logic [7:0] dexp;
  } vec_t;
  vec_t vecs[6];

  // S-box storage with one-cycle read latency.
  always @(posedge clk) begin
    if (sbox_rd_en) sbox_rd_data <= sbox_mem[sbox_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: inverse by definition, and first address whose value repeats.
  task automatic build_model(output int dup_addr);
    bit seen [256];
    dup_addr = -1;
    for (int v = 0; v < 256; v++) seen[v] = 1'b0;
    for (int a = 0; a < 256; a++) begin
      if (seen[sbox_mem[a]] && dup_addr < 0) dup_addr = a;
      seen[sbox_mem[a]] = 1'b1;
      model_inv[sbox_mem[a]] = 8'(a);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Starts a fill and checks the read sequence, write/error timing and gating.
  task automatic do_fill(input string tag, input bit hold_start);
    int dup_a, done_k, err_k, en_bad, addr_bad, gate_bad, n_en;
    build_model(dup_a);
    done_k = -1; err_k = -1; en_bad = 0; addr_bad = 0; gate_bad = 0; n_en = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = hold_start;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (sbox_rd_en !== 1'(k < 256)) en_bad++;
      if (sbox_rd_en === 1'b1) begin
        if (sbox_rd_addr !== 8'(n_en)) addr_bad++;
        n_en++;
      end
      if (done_inv === 1'b1 && done_k < 0) done_k = k;
      if (err_dup === 1'b1 && err_k < 0) err_k = k;
      if (done_inv !== 1'b1 && (in_ready !== 1'b0 || out_valid !== 1'b0)) gate_bad++;
      in_data = 8'($urandom);
      if (done_inv === 1'b1) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk({tag, "_rd_en_window"}, en_bad, 0);
    chk({tag, "_rd_addr_seq"}, addr_bad, 0);
    chk({tag, "_rd_count"}, n_en, 256);
    chk({tag, "_done_cycle"}, done_k, (dup_a < 0) ? 257 : -1);
    chk({tag, "_err_cycle"}, err_k, (dup_a < 0) ? -1 : dup_a + 2);
    chk({tag, "_no_accept_before_done"}, gate_bad, 0);
  endtask

  task automatic directed(input int kind);
    foreach (vecs[i]) begin
      if (vecs[i].kind == kind) begin
        in_valid = 1'b1; in_data = vecs[i].din; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("dir%0d_valid_%02h", kind, vecs[i].din), 32'(out_valid), 1);
        chk($sformatf("dir%0d_data_%02h", kind, vecs[i].din), 32'(out_data), 32'(vecs[i].dexp));
        @(posedge clk); #1;
      end
    end
  endtask

  // Randomized stream against a one-deep result queue of model lookups.
  task automatic stream(input string tag, input int n, input int pv, input int pr,
                        input bit seq, output int acc, output int drn);
    int idx;
    idx = 0; acc = 0; drn = 0;
    for (int c = 0; c < n; c++) begin
      in_valid  = 1'($urandom_range(99) < pv);
      in_data   = seq ? 8'(idx) : 8'($urandom);
      out_ready = 1'($urandom_range(99) < pr);
      @(negedge clk);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_q.size() == 0 || out_ready));
      if (exp_q.size() != 0) chk({tag, "_out_data"}, 32'(out_data), 32'(exp_q[0]));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        drn++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_inv[in_data]);
        acc++;
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, drn, cnt, found, j;
    logic [7:0] tmp;
    vecs[0] = '{0, 8'h00, 8'h00};
    vecs[1] = '{0, 8'h7F, 8'h7F};
    vecs[2] = '{0, 8'hFF, 8'hFF};
    vecs[3] = '{1, 8'h00, 8'hA5};
    vecs[4] = '{1, 8'hA5, 8'h00};
    vecs[5] = '{1, 8'hFF, 8'h5A};

    // Reset values
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(sbox_rd_en), 0);
    chk("rst_rd_addr", 32'(sbox_rd_addr), 0);
    chk("rst_done", 32'(done_inv), 0);
    chk("rst_err", 32'(err_dup), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst = 1'b0;

    // Identity S-box
    for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
    do_fill("ident", 1'b0);
    chk("ident_err_final", 32'(err_dup), 0);
    directed(0);
    stream("ident_rand", 200, 70, 60, 1'b0, acc, drn);
    stream("ident_flush", 2, 0, 100, 1'b0, acc, drn);

    // XOR S-box: directed, full throughput, backpressure
    do_reset();
    for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i) ^ 8'hA5;
    do_fill("xor", 1'b0);
    directed(1);
    stream("xor_tput", 256, 100, 100, 1'b1, acc, drn);
    chk("xor_tput_accepts", acc, 256);
    chk("xor_tput_results", drn, 255);
    stream("xor_tput_tail", 2, 0, 100, 1'b0, acc, drn);
    chk("xor_tput_tail", drn, 1);
    stream("xor_bp", 5, 100, 0, 1'b0, acc, drn);
    chk("xor_bp_accepts", acc, 1);
    chk("xor_bp_results", drn, 0);
    stream("xor_release", 10, 100, 100, 1'b0, acc, drn);
    chk("xor_release_results", drn, 10);
    stream("xor_flush", 2, 0, 100, 1'b0, acc, drn);

    // Duplicate value: sbox[0x10] = 0x20
    do_reset();
    for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
    sbox_mem[8'h10] = 8'h20;
    do_fill("dup", 1'b0);
    cnt = 0;
    in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
      if (done_inv !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || sbox_rd_en !== 1'b0) cnt++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("dup_error_hold", cnt, 0);
    chk("dup_err_sticky", 32'(err_dup), 1);

    // Reset in the middle of a fill, then a clean refill
    do_reset();
    for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      if (sbox_rd_en === 1'b1 && sbox_rd_addr === 8'h80) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("midrst_reached_0x80", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rd_en", 32'(sbox_rd_en), 0);
    chk("midrst_done", 32'(done_inv), 0);
    chk("midrst_rd_addr", 32'(sbox_rd_addr), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    exp_q.delete();
    do_fill("refill", 1'b0);
    chk("refill_err", 32'(err_dup), 0);
    stream("refill_rand", 100, 80, 80, 1'b0, acc, drn);
    stream("refill_flush", 2, 0, 100, 1'b0, acc, drn);

    // Random permutation, start held high throughout
    do_reset();
    for (int i = 0; i < 256; i++) sbox_mem[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i));
      tmp = sbox_mem[i]; sbox_mem[i] = sbox_mem[j]; sbox_mem[j] = tmp;
    end
    do_fill("perm", 1'b1);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (sbox_rd_en !== 1'b0 || done_inv !== 1'b1) cnt++;
    end
    chk("perm_no_refill", cnt, 0);
    stream("perm_rand", 300, 75, 65, 1'b0, acc, drn);
    start = 1'b0;
    stream("perm_flush", 2, 0, 100, 1'b0, acc, drn);
    chk("perm_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
